pipeline_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Merges three stall sources into one consistent set of per-stage register enables and flushes: the combinational hazard stall from the decode-stage hazard detector, a multi-cycle data-memory wait handshake, and a halt instruction retiring in WB.
- Also resolves taken-branch flushes and keeps a saturating stall-cycle counter plus a memory-timeout error state.
- Sits beside the hazard detector and drives the PC and the pipeline register banks.

---
 rtl/pipeline_stall_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Merges the decode-stage hazard stall, a multi-cycle data-memory wait and
//   a halt retiring in WB into one consistent set of per-stage enables and
//   flushes. It also resolves taken-branch flushes, counts stalled cycles
//   (saturating) and traps a memory wait that never completes into ERROR.
//
//   Handshake: a MEM-stage access (MemReq_M) completes on the cycle that
//   MemReady_M is high; while MemReq_M=1 and MemReady_M=0 the pipeline is
//   frozen and the request must be held stable until MemReady_M is seen.
//
// Ports
//   CLK, RESET      rising-edge clock, asynchronous active-high reset
//   HazardStall     load-use / branch-operand stall from the hazard detector
//   BranchTaken_D   branch in ID resolved taken this cycle
//   MemReq_M        MEM-stage instruction accesses data memory
//   MemReady_M      data memory completes the access this cycle
//   Halt_W          halt instruction valid in WB
//   Resume          restart request while HALTED
//   PCEN            PC write enable
//   IFIDEN/IFIDFlush, IDEXEN/IDEXFlush, EXMEMEN   pipeline register controls
//   MEMWBBubble     load a bubble into MEM/WB instead of the MEM result
//   State           0=RUN 1=MEM_WAIT 2=HALTED 3=ERROR (debug/status)
//   StallCount      saturating count of cycles with PCEN=0 in RUN/MEM_WAIT
//   Error           high iff State==ERROR
module pipeline_stall_ctrl #(
   parameter int WAIT_MAX = 16,
   parameter int WAIT_W   = 5,
   parameter int CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             HazardStall,
   input  logic             BranchTaken_D,
   input  logic             MemReq_M,
   input  logic             MemReady_M,
   input  logic             Halt_W,
   input  logic             Resume,
   output logic             PCEN,
   output logic             IFIDEN,
   output logic             IFIDFlush,
   output logic             IDEXEN,
   output logic             IDEXFlush,
   output logic             EXMEMEN,
   output logic             MEMWBBubble,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] StallCount,
   output logic             Error
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2,
      ST_ERROR    = 2'd3
   } state_t;

   // One extra bit so "counter + 1" can exceed the counter range cleanly.
   localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W+1)'(WAIT_MAX);

   state_t              state_q;
   state_t              state_d;
   logic [WAIT_W-1:0]   wait_q;
   logic [WAIT_W-1:0]   wait_d;
   logic [WAIT_W:0]     wait_inc;
   logic [CNT_W-1:0]    cnt_q;
   logic                run_eval;
   logic                miss_eff;
   logic                count_en;

   assign wait_inc = {1'b0, wait_q} + {{WAIT_W{1'b0}}, 1'b1};

   // State, wait counter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state and Mealy control outputs.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      run_eval    = 1'b0;
      miss_eff    = 1'b0;
      PCEN        = 1'b1;
      IFIDEN      = 1'b1;
      IFIDFlush   = 1'b0;
      IDEXEN      = 1'b1;
      IDEXFlush   = 1'b0;
      EXMEMEN     = 1'b1;
      MEMWBBubble = 1'b0;

      case (state_q)
         ST_RUN: begin
            run_eval = 1'b1;
            miss_eff = MemReq_M & ~MemReady_M;
         end
         ST_MEM_WAIT: begin
            if (MemReady_M) begin
               // Access completes: behave as RUN with no memory request.
               run_eval = 1'b1;
               miss_eff = 1'b0;
               wait_d   = '0;
            end else begin
               PCEN        = 1'b0;
               IFIDEN      = 1'b0;
               IDEXEN      = 1'b0;
               EXMEMEN     = 1'b0;
               MEMWBBubble = 1'b1;
               if (wait_inc > WAIT_LIMIT) begin
                  state_d = ST_ERROR;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_inc[WAIT_W-1:0];
               end
            end
         end
         ST_HALTED: begin
            PCEN        = 1'b0;
            IFIDEN      = 1'b0;
            IDEXEN      = 1'b0;
            EXMEMEN     = 1'b0;
            MEMWBBubble = 1'b1;
            // Outputs stay frozen on the Resume cycle; RUN starts next cycle.
            if (Resume) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            // ST_ERROR: sticky until RESET.
            PCEN        = 1'b0;
            IFIDEN      = 1'b0;
            IDEXEN      = 1'b0;
            EXMEMEN     = 1'b0;
            MEMWBBubble = 1'b1;
         end
      endcase

      // Priority: memory miss > halt > hazard stall > branch flush.
      if (run_eval) begin
         if (miss_eff) begin
            PCEN        = 1'b0;
            IFIDEN      = 1'b0;
            IDEXEN      = 1'b0;
            EXMEMEN     = 1'b0;
            MEMWBBubble = 1'b1;
            state_d     = ST_MEM_WAIT;
            wait_d      = {{(WAIT_W-1){1'b0}}, 1'b1};
         end else if (Halt_W) begin
            // The halting instruction retires this cycle; everything behind
            // it is frozen and a bubble follows it into MEM/WB.
            PCEN        = 1'b0;
            IFIDEN      = 1'b0;
            IDEXEN      = 1'b0;
            EXMEMEN     = 1'b0;
            MEMWBBubble = 1'b1;
            state_d     = ST_HALTED;
         end else if (HazardStall) begin
            // Branch operands are not yet valid, so BranchTaken_D is ignored.
            PCEN      = 1'b0;
            IFIDEN    = 1'b0;
            IDEXFlush = 1'b1;
            state_d   = ST_RUN;
         end else if (BranchTaken_D) begin
            IFIDFlush = 1'b1;
            state_d   = ST_RUN;
         end else begin
            state_d   = ST_RUN;
         end
      end

      // While in reset the pipeline is held with a bubble in MEM/WB.
      if (RESET) begin
         PCEN        = 1'b0;
         IFIDEN      = 1'b0;
         IFIDFlush   = 1'b0;
         IDEXEN      = 1'b0;
         IDEXFlush   = 1'b0;
         EXMEMEN     = 1'b0;
         MEMWBBubble = 1'b1;
      end
   end

   // Count only stalls seen by a live pipeline, never in HALTED/ERROR.
   assign count_en = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !PCEN;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign State      = state_q;
   assign StallCount = cnt_q;
   assign Error      = (state_q == ST_ERROR);

endmodule
